store_narrow_unit: RTL and testbench
====================================

# store_narrow_unit

Store-side partner of the pipeline's load sign-extension path: it takes 32-bit store requests of byte, halfword or word size and narrows the source data to the addressed lanes. Data memory accepts whole words only, so sub-word stores use a read-modify-write sequence. The block sits between the MEM stage and a handshaked word-only data memory. It reports completion or misalignment back to the pipeline.

## Interface
Parameters: none (data and address width fixed at 32).
- clk_i  input  1  rising-edge clock
- rst_i  input  1  asynchronous, active-low reset
- req_valid_i  input  1  store request valid
- req_ready_o  output  1  block idle and able to accept a request
- req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_addr_i  input  32  byte address
- req_data_i  input  32  source register value; low bits used for sub-word
- mem_re_o  output  1  word read request
- mem_we_o  output  1  word write request
- mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata_o  output  32  merged write word
- mem_rdata_i  input  32  read data, valid when mem_ack_i is high during a read
- mem_ack_i  input  1  memory accepts and completes the current access this cycle
- done_o  output  1  one-cycle pulse: store completed
- err_o  output  1  one-cycle pulse: request rejected

## Operation
- States:
  - IDLE: req_ready_o=1.
  - RD: mem_re_o=1.
  - WR: mem_we_o=1.
  - All outputs except req_ready_o/mem_re_o/mem_we_o are registered; those three are decoded from state only.
- Acceptance: a request is accepted on a rising edge with req_valid_i && req_ready_o. The block latches address, size and data.
- Rejection (no memory access, stay IDLE, err_o=1 next cycle) occurs on any of:
  - size 11
  - halfword with addr[0]=1
  - word with addr[1:0]!=00
- Word store: IDLE→WR directly; merge register = req_data_i.
- Byte/halfword store: IDLE→RD.
- Lane rules (little-endian):
  - Byte k=addr[1:0] replaces bits [8k+7:8k] with req_data_i[7:0].
  - Halfword h=addr[1] replaces bits [16h+15:16h] with req_data_i[15:0].
  - Upper source bits are discarded.
- RD: hold mem_re_o, mem_addr_o stable until mem_ack_i. On the ack edge, merge mem_rdata_i with the lane data into mem_wdata_o, then go to WR.
- WR: hold mem_we_o, mem_addr_o, mem_wdata_o stable until mem_ack_i. On the ack edge, go to IDLE and set done_o for the following cycle.
- mem_ack_i in IDLE is ignored.
- req_valid_i while not ready is ignored; the request is not queued.
- mem_addr_o/mem_wdata_o keep their last values in IDLE.
- Reset (asserted at any time, including mid-RD/WR):
  - state→IDLE; mem_re_o, mem_we_o, done_o, err_o→0 immediately.
  - mem_addr_o, mem_wdata_o→0; req_ready_o→1.
  - The interrupted store is abandoned with no done_o.

## Timing
- Word store, zero-wait memory: accept at edge 0, WR during cycle 1, ack at edge 1, done_o high in cycle 2. Latency is 2 cycles.
- Sub-word store, zero-wait memory: RD cycle 1, WR cycle 2, done_o cycle 3. Latency is 3 cycles.
- Each wait cycle of mem_ack_i adds one cycle.
- err_o is high in the cycle after acceptance. req_ready_o stays 1, so a new request can be accepted in that same cycle.
- done_o and the first IDLE cycle coincide, so back-to-back requests are accepted every 2 (word) or 3 (sub-word) cycles.
- mem_re_o and mem_we_o are never high together.

## Test plan
- Reset: hold rst_i=0 with random inputs → req_ready_o=1, all other outputs 0; release → no activity until req_valid_i.
- Word store at 0x10 of 0xDEADBEEF with zero-wait ack → no mem_re_o; one mem_we_o cycle, addr 0x10, wdata 0xDEADBEEF; done_o one cycle later.
- Byte store addr 0x22, data 0xFFFFFFAB, memory word 0x11223344 → read addr 0x20, write 0x11AB3344, done_o.
- Halfword addr 0x26, data 0x0000CAFE, memory 0x11223344 → write 0xCAFE3344. Repeat with addr 0x24 → 0x1122CAFE.
- Misaligned halfword 0x21, word 0x22, size 11 → err_o pulse each time; mem_re_o/mem_we_o never asserted; req_ready_o stays 1.
- Byte store with mem_ack_i withheld 3 cycles in RD and 2 in WR → outputs stable while waiting; extra req_valid_i ignored; done_o at cycle 8. Then repeat with rst_i asserted during WR → mem_we_o drops at once, no done_o, next store completes normally.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: turns byte/halfword/word stores into word-only memory
// accesses, using read-modify-write for sub-word sizes.
module store_narrow_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] lane_q, lane_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        illegal;

  always_comb begin
    case (req_size_i)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = req_addr_i[0];
      2'b10:   illegal = (req_addr_i[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Sub-word stores keep a lane mask and replicated source data so the RD
  // ack only has to blend the returned word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            addr_d = {req_addr_i[31:2], 2'b00};
            case (req_size_i)
              2'b10: begin
                wdata_d = req_data_i;
                state_d = WR;
              end
              2'b01: begin
                mask_d  = req_addr_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_d  = {2{req_data_i[15:0]}};
                state_d = RD;
              end
              default: begin
                mask_d  = 32'h0000_00FF << {req_addr_i[1:0], 3'b000};
                lane_d  = {4{req_data_i[7:0]}};
                state_d = RD;
              end
            endcase
          end
        end
      end
      RD: begin
        if (mem_ack_i) begin
          wdata_d = (mem_rdata_i & ~mask_q) | (lane_q & mask_q);
          state_d = WR;
        end
      end
      WR: begin
        if (mem_ack_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mask_q  <= 32'h0;
      lane_q  <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_re_o    = (state_q == RD);
  assign mem_we_o    = (state_q == WR);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: drives stores against a bench-side word memory
// response and scores the merged write words through a queue.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        mem_re_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        done_o, err_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   asserts = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  store_narrow_unit dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_size_i  (req_size),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  function automatic logic [31:0] merge_model(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] data, input logic [31:0] mem);
    logic [31:0] w;
    int k;
    w = mem;
    if (size == 2'b00) begin
      k = int'(addr[1:0]);
      w[8*k +: 8] = data[7:0];
    end else if (size == 2'b01) begin
      k = int'(addr[1]);
      w[16*k +: 16] = data[15:0];
    end else begin
      w = data;
    end
    return w;
  endfunction

  // Drives one legal store at the current negedge and walks it to its done cycle.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] mem, input int rdWait, input int wrWait, input bit abortInWr);
    exp_t e, got;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = merge_model(size, addr, data, mem);
    sb.push_back(e);
    req_valid = 1'b1; req_size = size; req_addr = addr; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;
    if (size != 2'b10) begin
      for (int i = 0; i <= rdWait; i++) begin
        asserts++;
        if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b01000 || mem_addr_o !== e.addr) begin
          failures++;
          $display("[TB] FAIL rd_phase cyc%0d: flags=%b addr=%h, want flags=01000 addr=%h",
                   i, {req_ready_o, mem_re_o, mem_we_o, done_o, err_o}, mem_addr_o, e.addr);
        end
        if (i < rdWait) begin
          mem_ack = 1'b0; mem_rdata = $urandom;
          req_valid = 1'b1; req_size = 2'($urandom_range(0, 2)); req_addr = $urandom; req_data = $urandom;
        end else begin
          req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = mem;
        end
        @(negedge clk);
      end
      mem_ack = 1'b0; req_valid = 1'b0; mem_rdata = $urandom;
    end
    for (int i = 0; i <= wrWait; i++) begin
      asserts++;
      if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b00100 ||
          mem_addr_o !== e.addr || mem_wdata_o !== e.wdata) begin
        failures++;
        $display("[TB] FAIL wr_phase cyc%0d: flags=%b addr=%h wdata=%h, want flags=00100 addr=%h wdata=%h",
                 i, {req_ready_o, mem_re_o, mem_we_o, done_o, err_o}, mem_addr_o, mem_wdata_o, e.addr, e.wdata);
      end
      if (abortInWr) begin
        rst_i = 1'b0;
        #1;
        asserts++;
        if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b10000 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
          failures++;
          $display("[TB] FAIL reset_in_wr: flags=%b addr=%h wdata=%h, want flags=10000 addr=0 wdata=0",
                   {req_ready_o, mem_re_o, mem_we_o, done_o, err_o}, mem_addr_o, mem_wdata_o);
        end
        void'(sb.pop_front());
        @(negedge clk);
        rst_i = 1'b1;
        for (int j = 0; j < 2; j++) begin
          asserts++;
          if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL after_abort cyc%0d: flags=%b, want 10000",
                     j, {req_ready_o, mem_re_o, mem_we_o, done_o, err_o});
          end
          @(negedge clk);
        end
        return;
      end
      if (i < wrWait) begin
        mem_ack = 1'b0; mem_rdata = $urandom;
        req_valid = 1'b1; req_size = 2'($urandom_range(0, 2)); req_addr = $urandom; req_data = $urandom;
      end else begin
        req_valid = 1'b0; mem_ack = 1'b1;
        got = sb.pop_front();
        asserts++;
        if (mem_addr_o !== got.addr || mem_wdata_o !== got.wdata) begin
          failures++;
          $display("[TB] FAIL scoreboard_write: addr=%h wdata=%h, want addr=%h wdata=%h",
                   mem_addr_o, mem_wdata_o, got.addr, got.wdata);
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; req_valid = 1'b0;
    asserts++;
    if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b10010) begin
      failures++;
      $display("[TB] FAIL done_pulse: flags=%b, want 10010", {req_ready_o, mem_re_o, mem_we_o, done_o, err_o});
    end
  endtask

  task automatic check_quiet(input string name);
    asserts++;
    if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL %s: flags=%b, want 10000", name, {req_ready_o, mem_re_o, mem_we_o, done_o, err_o});
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_data = $urandom;
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      asserts++;
      if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b10000 ||
          mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold cyc%0d: flags=%b addr=%h wdata=%h, want flags=10000 addr=0 wdata=0",
                 i, {req_ready_o, mem_re_o, mem_we_o, done_o, err_o}, mem_addr_o, mem_wdata_o);
      end
    end
    req_valid = 1'b0;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      check_quiet("reset_release");
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_word();
    $display("[TB] word store");
    do_store(2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    check_quiet("word_after_done");
  endtask

  task automatic test_byte();
    $display("[TB] byte store");
    do_store(2'b00, 32'h22, 32'hFFFFFFAB, 32'h11223344, 0, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_half();
    $display("[TB] halfword stores");
    do_store(2'b01, 32'h26, 32'h0000CAFE, 32'h11223344, 0, 0, 1'b0);
    @(negedge clk);
    do_store(2'b01, 32'h24, 32'h0000CAFE, 32'h11223344, 0, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] addrs [3] = '{32'h21, 32'h22, 32'h20};
    $display("[TB] rejected requests");
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_size = sizes[i]; req_addr = addrs[i]; req_data = $urandom;
      @(negedge clk);
      asserts++;
      if ({req_ready_o, mem_re_o, mem_we_o, done_o, err_o} !== 5'b10001) begin
        failures++;
        $display("[TB] FAIL reject%0d: flags=%b, want 10001", i, {req_ready_o, mem_re_o, mem_we_o, done_o, err_o});
      end
    end
    // A legal store accepted in the err_o cycle of the last rejection.
    do_store(2'b10, 32'h40, 32'h0BADF00D, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    check_quiet("after_reject_store");
  endtask

  task automatic test_wait_states();
    $display("[TB] wait states");
    do_store(2'b00, 32'h33, 32'h123456C3, 32'hA5A5A5A5, 3, 2, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wr();
    $display("[TB] reset during write");
    do_store(2'b00, 32'h51, 32'h77, 32'h01020304, 1, 2, 1'b1);
    do_store(2'b00, 32'h51, 32'h77, 32'h01020304, 0, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    $display("[TB] back-to-back stores");
    do_store(2'b10, 32'h100, $urandom, 32'h0, 0, 0, 1'b0);
    do_store(2'b00, 32'h105, $urandom, $urandom, 0, 0, 1'b0);
    do_store(2'b01, 32'h10A, $urandom, $urandom, 0, 0, 1'b0);
    do_store(2'b10, 32'h10C, $urandom, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    check_quiet("b2b_end");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_wait_states();
    test_reset_mid_wr();
    test_back_to_back();
    asserts++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
